// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU AXI4-Lite initiator.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } lsu_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle, 32-bit address and data, with initiator/target views.
interface axi_lite_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replication, load shift and extension,
// and alignment checking for byte/half/word accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        size_invalid
);

    logic [31:0] rdata_shift;

    always_comb begin
        rdata_shift  = rdata >> {addr_lo, 3'b000};
        wstrb        = 4'b0000;
        wdata_lane   = wdata;
        rdata_ext    = rdata_shift;
        misaligned   = 1'b0;
        size_invalid = 1'b0;
        case (size)
            SZ_B: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = is_unsigned ? {24'h0, rdata_shift[7:0]}
                                         : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            end
            SZ_H: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'h0, rdata_shift[15:0]}
                                         : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
                misaligned = addr_lo[0];
            end
            SZ_W: begin
                wstrb      = 4'b1111;
                misaligned = |addr_lo;
            end
            default: begin
                // 2'b11 has no meaning; it is rejected like a misaligned access
                misaligned   = 1'b1;
                size_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// AXI4-Lite initiator for the LSU: one outstanding load or store, converted
// into a read or write transaction with lane steering and error reporting.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; misaligned ones go straight to RESP
// RD_ADDR | arvalid held until arready
// RD_DATA | rready held until rvalid; load data extended and captured
// WR_REQ  | awvalid/wvalid held independently until each handshakes
// WR_RESP | bready held until bvalid
// RESP    | rsp_valid held, outputs frozen until rsp_ready
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter int MISALIGN_TRAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    axi_lite_if.master  m
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        aw_done;
    logic        w_done;

    logic [1:0]  al_addr;
    logic [1:0]  al_size;
    logic        al_unsigned;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;
    logic        al_size_invalid;
    logic        trap;
    logic        aw_hs;
    logic        w_hs;

    // In IDLE the aligner looks at the incoming request so strobes and the
    // trap decision are ready at accept; afterwards it sees the latched one.
    assign al_addr     = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_size     = (state == IDLE) ? req_size      : size_q;
    assign al_unsigned = (state == IDLE) ? req_unsigned  : unsigned_q;

    lsu_align u_align (
        .addr_lo      (al_addr),
        .size         (al_size),
        .is_unsigned  (al_unsigned),
        .wdata        (req_wdata),
        .rdata        (m.rdata),
        .wstrb        (al_wstrb),
        .wdata_lane   (al_wdata),
        .rdata_ext    (al_rdata),
        .misaligned   (al_misaligned),
        .size_invalid (al_size_invalid)
    );

    assign trap     = al_size_invalid | ((MISALIGN_TRAP != 0) & al_misaligned);
    assign aw_hs    = m.awvalid & m.awready;
    assign w_hs     = m.wvalid & m.wready;
    assign m.araddr = addr_q;
    assign m.awaddr = addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
            m.arvalid  <= 1'b0;
            m.rready   <= 1'b0;
            m.awvalid  <= 1'b0;
            m.wvalid   <= 1'b0;
            m.bready   <= 1'b0;
            m.wdata    <= 32'h0;
            m.wstrb    <= 4'h0;
            addr_q     <= 32'h0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        m.wdata    <= al_wdata;
                        m.wstrb    <= al_wstrb;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        if (trap) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else if (req_we) begin
                            state     <= WR_REQ;
                            m.awvalid <= 1'b1;
                            m.wvalid  <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            m.arvalid <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m.arready) begin
                        m.arvalid <= 1'b0;
                        m.rready  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m.rvalid) begin
                        m.rready  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= (m.rresp != RESP_OKAY);
                        rsp_rdata <= (m.rresp != RESP_OKAY) ? 32'h0 : al_rdata;
                        state     <= RESP;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        m.awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        m.wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        m.bready <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m.bvalid) begin
                        m.bready  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= (m.bresp != RESP_OKAY);
                        rsp_rdata <= 32'h0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: loads, stores in several handshake
// orders, bus errors, misalignment trap, backpressure and mid-read reset.
module tb_lsu_axi_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_assert = 0;
    int n_fail   = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int axi_vcnt = 0;

    always #5 clk = ~clk;

    axi_lite_if bus ();

    lsu_axi_master #(.MISALIGN_TRAP(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .m            (bus)
    );

    always @(posedge clk) begin
        if (bus.awvalid && bus.awready) aw_cnt++;
        if (bus.wvalid && bus.wready) w_cnt++;
        if (bus.arvalid || bus.awvalid || bus.wvalid) axi_vcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    // Zero-wait load; called and returning at a negedge.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata, input logic [1:0] rresp,
                           input logic [31:0] exp_data, input logic exp_err);
        chk({tag, "/req_ready0"}, req_ready, 1);
        set_req(1'b0, addr, size, uns, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "/arvalid1"}, bus.arvalid, 1);
        chk({tag, "/araddr"}, bus.araddr, addr);
        chk({tag, "/rsp_valid1"}, rsp_valid, 0);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        chk({tag, "/arvalid2"}, bus.arvalid, 0);
        chk({tag, "/rready2"}, bus.rready, 1);
        bus.rvalid = 1'b1;
        bus.rdata  = rdata;
        bus.rresp  = rresp;
        @(negedge clk);
        bus.rvalid = 1'b0;
        chk({tag, "/rready3"}, bus.rready, 0);
        chk({tag, "/rsp_valid3"}, rsp_valid, 1);
        chk({tag, "/rsp_rdata"}, rsp_rdata, exp_data);
        chk({tag, "/rsp_err"}, rsp_err, exp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "/rsp_valid4"}, rsp_valid, 0);
        chk({tag, "/req_ready4"}, req_ready, 1);
    endtask

    // Store with AW ready after aw_d cycles and W ready after w_d cycles.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input int aw_d, input int w_d,
                            input logic [1:0] bresp, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input logic exp_err);
        int aw0  = aw_cnt;
        int w0   = w_cnt;
        int last = 1 + ((aw_d > w_d) ? aw_d : w_d);
        set_req(1'b1, addr, size, 1'b0, wdata);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk({tag, "/awvalid"}, bus.awvalid, 32'(c <= 1 + aw_d));
            chk({tag, "/wvalid"}, bus.wvalid, 32'(c <= 1 + w_d));
            if (c <= 1 + aw_d) chk({tag, "/awaddr"}, bus.awaddr, addr);
            if (c <= 1 + w_d) begin
                chk({tag, "/wstrb"}, bus.wstrb, exp_strb);
                chk({tag, "/wdata"}, bus.wdata, exp_wdata);
            end
            chk({tag, "/bready_early"}, bus.bready, 0);
            bus.awready = (c == 1 + aw_d);
            bus.wready  = (c == 1 + w_d);
        end
        @(negedge clk);
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        chk({tag, "/bready"}, bus.bready, 1);
        chk({tag, "/awvalid_off"}, bus.awvalid, 0);
        chk({tag, "/wvalid_off"}, bus.wvalid, 0);
        bus.bvalid = 1'b1;
        bus.bresp  = bresp;
        @(negedge clk);
        bus.bvalid = 1'b0;
        chk({tag, "/rsp_valid"}, rsp_valid, 1);
        chk({tag, "/rsp_err"}, rsp_err, exp_err);
        chk({tag, "/rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "/aw_count"}, aw_cnt - aw0, 1);
        chk({tag, "/w_count"}, w_cnt - w0, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "/rsp_valid_off"}, rsp_valid, 0);
    endtask

    initial begin
        int v0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        bus.arready  = 1'b0;
        bus.rdata    = 32'h0;
        bus.rresp    = 2'b00;
        bus.rvalid   = 1'b0;
        bus.awready  = 1'b0;
        bus.wready   = 1'b0;
        bus.bresp    = 2'b00;
        bus.bvalid   = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset/req_ready", req_ready, 1);
        chk("reset/rsp_valid", rsp_valid, 0);
        chk("reset/rsp_err", rsp_err, 0);
        chk("reset/rsp_rdata", rsp_rdata, 0);
        chk("reset/valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 0);
        chk("reset/state", dut.state, IDLE);
        reset = 1'b0;
        @(negedge clk);

        do_load("ld_word", 32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);
        do_load("ld_byte_s", 32'h8000_0003, 2'b00, 1'b0, 32'h8000_0000, 2'b00, 32'hFFFF_FF80, 1'b0);
        do_load("ld_byte_u", 32'h8000_0003, 2'b00, 1'b1, 32'h8000_0000, 2'b00, 32'h0000_0080, 1'b0);
        do_load("ld_half_s", 32'h8000_0002, 2'b01, 1'b0, 32'h8001_1234, 2'b00, 32'hFFFF_8001, 1'b0);
        do_load("ld_rresp3", 32'h8000_0000, 2'b10, 1'b0, 32'h1234_5678, 2'b11, 32'h0, 1'b1);

        do_store("st_w_first", 32'h8000_0002, 2'b01, 32'h0000_1234, 3, 0, 2'b00, 4'b1100, 32'h1234_1234, 1'b0);
        do_store("st_aw_first", 32'h8000_0002, 2'b01, 32'h0000_1234, 0, 2, 2'b00, 4'b1100, 32'h1234_1234, 1'b0);
        do_store("st_together", 32'h8000_0002, 2'b01, 32'h0000_1234, 0, 0, 2'b00, 4'b1100, 32'h1234_1234, 1'b0);
        do_store("st_byte", 32'h8000_0001, 2'b00, 32'hFFFF_FFA5, 1, 1, 2'b00, 4'b0010, 32'hA5A5_A5A5, 1'b0);
        do_store("st_slverr", 32'h8000_0008, 2'b10, 32'hCAFE_BABE, 0, 0, 2'b10, 4'b1111, 32'hCAFE_BABE, 1'b1);

        // Misaligned word load traps locally
        v0 = axi_vcnt;
        set_req(1'b0, 32'h8000_0002, 2'b10, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("trap/rsp_valid", rsp_valid, 1);
        chk("trap/rsp_err", rsp_err, 1);
        chk("trap/rsp_rdata", rsp_rdata, 0);
        chk("trap/arvalid", bus.arvalid, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("trap/rsp_valid_off", rsp_valid, 0);

        // Size 2'b11 is rejected even though the address is aligned
        set_req(1'b1, 32'h8000_0000, 2'b11, 1'b0, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("badsize/rsp_valid", rsp_valid, 1);
        chk("badsize/rsp_err", rsp_err, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("trap/no_axi_valid", axi_vcnt - v0, 0);

        // Response backpressure with a new request waiting
        set_req(1'b0, 32'h8000_0008, 2'b10, 1'b0, 32'h0);
        @(negedge clk);
        req_valid   = 1'b0;
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'hCAFE_F00D;
        bus.rresp   = 2'b00;
        @(negedge clk);
        bus.rvalid = 1'b0;
        set_req(1'b1, 32'h8000_0010, 2'b10, 1'b0, 32'h5555_AAAA);
        v0 = axi_vcnt;
        for (int i = 0; i < 5; i++) begin
            chk("hold/req_ready", req_ready, 0);
            chk("hold/rsp_valid", rsp_valid, 1);
            chk("hold/rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("hold/rsp_err", rsp_err, 0);
            @(negedge clk);
        end
        chk("hold/no_axi_valid", axi_vcnt - v0, 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold/release", rsp_valid, 0);

        // Reset while the read data phase is pending
        set_req(1'b0, 32'h8000_0004, 2'b10, 1'b0, 32'h0);
        @(negedge clk);
        req_valid   = 1'b0;
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        chk("rst_mid/rready", bus.rready, 1);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1111_2222;
        reset      = 1'b1;
        @(negedge clk);
        chk("rst_mid/valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, rsp_valid}, 0);
        chk("rst_mid/state", dut.state, IDLE);
        chk("rst_mid/req_ready", req_ready, 1);
        reset      = 1'b0;
        bus.rvalid = 1'b0;
        @(negedge clk);

        do_load("ld_after_rst", 32'h8000_0001, 2'b00, 1'b1, 32'h0000_7F00, 2'b00, 32'h0000_007F, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
